// File: rtl/alu_pipe_hs.sv
// Pipelined ALU with valid/ready handshakes: AND/OR/ADD/SUB/SLT in one cycle,
// optional iterative shift-add unsigned multiply (WIDTH+1 cycles).
//
// state  | meaning
// IDLE   | ready for operands; non-mul ops complete here on the accept edge
// MUL    | one shift-add step per cycle, LSB-first on B
// DONE   | multiply finished; loads the output register and returns to IDLE
module alu_pipe_hs #(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             op0,
  input  logic             op1,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int       CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam bit       MUL_ON   = (MUL_EN != 0);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic                 z_q, c_q, v_q;
  logic [2*WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]     b_sh_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;

  logic                 accept, mul_go;
  logic                 sub_eff, ovf;
  logic [WIDTH-1:0]     b_eff;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     res_d;
  logic                 c_d, v_d;
  logic [2*WIDTH-1:0]   acc_d;

  assign in_ready = rst_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_go   = MUL_ON && mul;

  // SLT always subtracts; sub only matters for the ADD encoding
  assign sub_eff = (op1 && op0) || (sub && !op1 && op0);
  assign b_eff   = sub_eff ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub_eff);
  assign ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case ({op1, op0})
      2'b00: res_d = a & b;
      2'b10: res_d = a | b;
      2'b01: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = ovf;
      end
      default: begin
        res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
        c_d   = sum[WIDTH];
        v_d   = ovf;
      end
    endcase
  end

  assign acc_d = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      // drain; any load below in the same edge takes precedence
      if (out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (mul_go) begin
              a_sh_q  <= {{WIDTH{1'b0}}, a};
              b_sh_q  <= b;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_MUL;
            end else begin
              result_q    <= res_d;
              z_q         <= (res_d == '0);
              c_q         <= c_d;
              v_q         <= v_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q  <= acc_d;
          a_sh_q <= a_sh_q << 1;
          b_sh_q <= b_sh_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_q <= S_DONE;
        end
        S_DONE: begin
          result_q    <= acc_q[WIDTH-1:0];
          z_q         <= (acc_q[WIDTH-1:0] == '0);
          c_q         <= |acc_q[2*WIDTH-1:WIDTH];
          v_q         <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Directed bench for alu_pipe_hs: one instance at WIDTH=16 and one at WIDTH=8,
// driven from shared stimulus and selected by sel8.
module tb_alu_pipe_hs;

  logic clk;
  logic rst_n;
  logic sel8;
  logic [63:0] a_s, b_s;
  logic sub_s, op0_s, op1_s, mul_s, in_valid_s, out_ready_s;

  logic ir16, ov16, z16, c16, v16;
  logic [15:0] r16;
  logic ir8, ov8, z8, c8, v8;
  logic [7:0] r8;

  logic o_ready, o_valid, o_z, o_c, o_v;
  logic [63:0] o_res;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_hs #(.WIDTH(16), .MUL_EN(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s && !sel8), .in_ready(ir16),
    .a(a_s[15:0]), .b(b_s[15:0]), .sub(sub_s), .op0(op0_s), .op1(op1_s), .mul(mul_s),
    .out_valid(ov16), .out_ready(out_ready_s), .result(r16),
    .flag_z(z16), .flag_c(c16), .flag_v(v16)
  );

  alu_pipe_hs #(.WIDTH(8), .MUL_EN(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s && sel8), .in_ready(ir8),
    .a(a_s[7:0]), .b(b_s[7:0]), .sub(sub_s), .op0(op0_s), .op1(op1_s), .mul(mul_s),
    .out_valid(ov8), .out_ready(out_ready_s), .result(r8),
    .flag_z(z8), .flag_c(c8), .flag_v(v8)
  );

  assign o_ready = sel8 ? ir8 : ir16;
  assign o_valid = sel8 ? ov8 : ov16;
  assign o_res   = sel8 ? {56'd0, r8} : {48'd0, r16};
  assign o_z     = sel8 ? z8 : z16;
  assign o_c     = sel8 ? c8 : c16;
  assign o_v     = sel8 ? v8 : v16;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input string tag, input logic [1:0] op, input logic s,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] er, input logic [2:0] ezcv);
    a_s = av; b_s = bv; {op1_s, op0_s} = op; sub_s = s; mul_s = 1'b0;
    in_valid_s = 1'b1; out_ready_s = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(o_ready), 64'd1);
    tick();
    in_valid_s = 1'b0;
    chk({tag, "_vld"}, 64'(o_valid), 64'd1);
    chk({tag, "_res"}, o_res, er);
    chk({tag, "_zcv"}, 64'({o_z, o_c, o_v}), 64'(ezcv));
  endtask

  task automatic run_mul(input string tag, input int w, input logic [63:0] av,
                         input logic [63:0] bv, input logic [63:0] er, input logic [2:0] ezcv);
    int n;
    int busy;
    a_s = av; b_s = bv; mul_s = 1'b1; sub_s = 1'b0; {op1_s, op0_s} = 2'b00;
    in_valid_s = 1'b1; out_ready_s = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(o_ready), 64'd1);
    tick();
    in_valid_s = 1'b0; mul_s = 1'b0;
    n = 0; busy = 0;
    while (!o_valid && n < w + 5) begin
      if (o_ready) busy++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(w + 1));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_res"}, o_res, er);
    chk({tag, "_zcv"}, 64'({o_z, o_c, o_v}), 64'(ezcv));
  endtask

  task automatic run_basic(input int w);
    logic wide;
    wide = (w == 16);
    sel8 = !wide;
    alu_op("and",    2'b00, 1'b0, 64'd5, 64'd2, 64'd0, 3'b100);
    alu_op("or",     2'b10, 1'b0, 64'd5, 64'd2, 64'd7, 3'b000);
    alu_op("add",    2'b01, 1'b0, 64'd5, 64'd2, 64'd7, 3'b000);
    alu_op("add44",  2'b01, 1'b0, 64'd4, 64'd4, 64'd8, 3'b000);
    alu_op("sub52",  2'b01, 1'b1, 64'd5, 64'd2, 64'd3, 3'b010);
    alu_op("sub25",  2'b01, 1'b1, 64'd2, 64'd5, wide ? 64'hFFFD : 64'hFD, 3'b000);
    alu_op("addovf", 2'b01, 1'b0, wide ? 64'h7FFF : 64'h7F, 64'd1,
           wide ? 64'h8000 : 64'h80, 3'b001);
    alu_op("sub55",  2'b01, 1'b1, 64'd5, 64'd5, 64'd0, 3'b110);
    alu_op("slt_lt", 2'b11, 1'b1, 64'd30, 64'd40, 64'd1, 3'b000);
    alu_op("slt_gt", 2'b11, 1'b1, 64'd40, 64'd30, 64'd0, 3'b110);
    alu_op("slt_min", 2'b11, 1'b1, wide ? 64'h8000 : 64'h80, 64'd1, 64'd1, 3'b011);
    alu_op("slt_lt_s0", 2'b11, 1'b0, 64'd30, 64'd40, 64'd1, 3'b000);
    alu_op("slt_min_s0", 2'b11, 1'b0, wide ? 64'h8000 : 64'h80, 64'd1, 64'd1, 3'b011);
    run_mul("mul200", w, 64'd100, 64'd2, 64'd200, 3'b000);
    run_mul("mulwrap", w, wide ? 64'h0100 : 64'h10, wide ? 64'h0100 : 64'h10, 64'd0, 3'b110);
  endtask

  initial begin
    int hold_err;
    int vcount;
    rst_n = 1'b0; sel8 = 1'b0;
    a_s = '0; b_s = '0; sub_s = 1'b0; op0_s = 1'b0; op1_s = 1'b0; mul_s = 1'b0;
    in_valid_s = 1'b0; out_ready_s = 1'b1;
    tick();
    tick();
    chk("rst_rdy", 64'(o_ready), 64'd0);
    chk("rst_vld", 64'(o_valid), 64'd0);
    chk("rst_res", o_res, 64'd0);
    chk("rst_zcv", 64'({o_z, o_c, o_v}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_rdy", 64'(o_ready), 64'd1);
    tick();

    run_basic(16);

    // backpressure at WIDTH=16
    sel8 = 1'b0;
    alu_op("bp_add", 2'b01, 1'b0, 64'd5, 64'd2, 64'd7, 3'b000);
    out_ready_s = 1'b0;
    a_s = 64'h00F0; b_s = 64'h000F; {op1_s, op0_s} = 2'b10; sub_s = 1'b0;
    in_valid_s = 1'b1;
    hold_err = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (o_ready || !o_valid || o_res != 64'd7) hold_err++;
      tick();
    end
    chk("bp_hold", 64'(hold_err), 64'd0);
    chk("bp_res_held", o_res, 64'd7);
    out_ready_s = 1'b1;
    #1;
    chk("bp_rel_rdy", 64'(o_ready), 64'd1);
    tick();
    in_valid_s = 1'b0;
    chk("bp_next_vld", 64'(o_valid), 64'd1);
    chk("bp_next_res", o_res, 64'h00FF);
    tick();
    chk("bp_drained", 64'(o_valid), 64'd0);

    // reset in the middle of a multiply
    a_s = 64'd100; b_s = 64'd3; mul_s = 1'b1; in_valid_s = 1'b1; out_ready_s = 1'b1;
    #1;
    chk("rmul_rdy", 64'(o_ready), 64'd1);
    tick();
    in_valid_s = 1'b0; mul_s = 1'b0;
    vcount = 0;
    for (int i = 0; i < 7; i++) begin
      if (o_valid) vcount++;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("rmul_rdy_low", 64'(o_ready), 64'd0);
    tick();
    chk("rmul_vld", 64'(o_valid), 64'd0);
    chk("rmul_res", o_res, 64'd0);
    chk("rmul_zcv", 64'({o_z, o_c, o_v}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rmul_rdy_back", 64'(o_ready), 64'd1);
    for (int i = 0; i < 21; i++) begin
      tick();
      if (o_valid) vcount++;
    end
    chk("rmul_no_out", 64'(vcount), 64'd0);

    run_basic(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
